// File: rtl/booth_div.sv
// rtl/booth_div.sv - sequential signed non-restoring divider, one quotient bit per cycle
module booth_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             data_result_ready,
   output logic             exception,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             rdy_q, rdy_d;
   logic             exc_q, exc_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   m_ext, a_sh, a_new, a_fix;
   logic [WIDTH-1:0] q_new, abs_dvd, abs_dvs;

   // A stays within [-2M, 2M), so W+1 bits hold it even when M = 2^(W-1)
   assign m_ext   = {1'b0, m_q};
   assign a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign a_new   = a_q[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
   assign q_new   = {q_q[WIDTH-2:0], ~a_new[WIDTH]};
   assign a_fix   = a_q[WIDTH] ? (a_q + m_ext) : a_q;
   assign abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign abs_dvs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      sgnq_d   = sgnq_q;
      sgnr_d   = sgnr_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      rem_d    = rem_q;
      rdy_d    = rdy_q;
      exc_d    = exc_q;
      busy_d   = busy_q;

      case (state_q)
         BUSY: begin
            if (div0_q || ovf_q) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               rdy_d    = 1'b1;
               exc_d    = 1'b1;
               result_d = ovf_q ? MIN_INT : '0;
               rem_d    = div0_q ? (sgnr_q ? (~q_q + 1'b1) : q_q) : '0;
            end else if (cnt_q == LAST) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               rdy_d    = 1'b1;
               a_d      = a_fix;
               result_d = sgnq_q ? (~q_q + 1'b1) : q_q;
               rem_d    = sgnr_q ? (~a_fix[WIDTH-1:0] + 1'b1) : a_fix[WIDTH-1:0];
            end else begin
               a_d   = a_new;
               q_d   = q_new;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      // A start pulse overrides everything, including a finalize in the same cycle
      if (ctrl_div) begin
         state_d = BUSY;
         sgnq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
         sgnr_d  = dividend[WIDTH-1];
         q_d     = abs_dvd;
         m_d     = abs_dvs;
         a_d     = '0;
         cnt_d   = '0;
         div0_d  = (divisor == '0);
         ovf_d   = (dividend == MIN_INT) && (divisor == '1);
         rdy_d   = 1'b0;
         exc_d   = 1'b0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         sgnq_q   <= 1'b0;
         sgnr_q   <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         rem_q    <= '0;
         rdy_q    <= 1'b0;
         exc_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         sgnq_q   <= sgnq_d;
         sgnr_q   <= sgnr_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         rdy_q    <= rdy_d;
         exc_q    <= exc_d;
         busy_q   <= busy_d;
      end
   end

   assign result            = result_q;
   assign remainder         = rem_q;
   assign data_result_ready = rdy_q;
   assign exception         = exc_q;
   assign busy              = busy_q;

endmodule
